// File: rtl/el_panel_scanout_if.sv
// Frame-buffer read port plus EL panel drive signals for the scan-out block.
// The master side is the scan-out engine; the slave side is RAM and panel.
interface el_panel_scanout_if;
  logic        enable;
  logic [14:0] rdAddr;
  logic [7:0]  rdData;
  logic [3:0]  elData;
  logic        elCp;
  logic        elLp;
  logic        elFlm;
  logic        subframe;
  logic        frameDone;

  modport master (
    input  enable, rdData,
    output rdAddr, elData, elCp, elLp, elFlm, subframe, frameDone
  );

  modport slave (
    output enable, rdData,
    input  rdAddr, elData, elCp, elLp, elFlm, subframe, frameDone
  );
endinterface

// File: rtl/el_panel_scanout.sv
// Reads packed 2-plane pixel bytes from the frame buffer and drives a 4-bit EL panel,
// alternating the low- and high-threshold planes on successive subframes.
module el_panel_scanout #(
  parameter int H_BYTES  = 80,
  parameter int V_LINES  = 240,
  parameter int RD_LAT   = 1,
  parameter int CP_DIV   = 2,
  parameter int LP_WIDTH = 4,
  parameter int LINE_GAP = 8
) (
  input  logic                clk,
  input  logic                reset,
  el_panel_scanout_if.master  bus
);

  localparam int CNT_W  = 16;
  localparam int LINE_W = $clog2(V_LINES);
  localparam int BYTE_W = $clog2(H_BYTES);

  localparam logic [CNT_W-1:0]  RD_LAST   = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0]  CP_LAST   = CNT_W'(CP_DIV - 1);
  localparam logic [CNT_W-1:0]  LP_LAST   = CNT_W'(LP_WIDTH - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(LINE_GAP - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_LINES - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(H_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WAIT, S_CP_LO, S_CP_HI, S_LATCH, S_GAP
  } state_t;

  state_t             state, stateNext;
  logic [CNT_W-1:0]   cnt;
  logic [LINE_W-1:0]  line;
  logic [BYTE_W-1:0]  byteIdx;
  logic [14:0]        rdAddrQ;
  logic [3:0]         elDataQ;
  logic               subframeQ;
  logic               frameDoneQ;
  logic               lastLine;
  logic               lastByte;
  logic               elCpC, elLpC, elFlmC;

  assign lastLine = (line == LINE_LAST);
  assign lastByte = (byteIdx == BYTE_LAST);

  // State register; cnt measures time spent in the current state.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= (stateNext != state) ? '0 : cnt + 1'b1;
    end
  end

  // NOTE: stateNext gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    stateNext = state;
    unique case (state)
      S_IDLE:  if (bus.enable) stateNext = S_ADDR;
      S_ADDR:  stateNext = S_WAIT;
      S_WAIT:  if (cnt == RD_LAST) stateNext = S_CP_LO;
      S_CP_LO: if (cnt == CP_LAST) stateNext = S_CP_HI;
      S_CP_HI: if (cnt == CP_LAST) stateNext = lastByte ? S_LATCH : S_ADDR;
      S_LATCH: if (cnt == LP_LAST) stateNext = S_GAP;
      S_GAP: begin
        // enable only matters at frame end; a started frame always completes
        if (cnt == GAP_LAST) stateNext = (!lastLine || bus.enable) ? S_ADDR : S_IDLE;
      end
      default: stateNext = S_IDLE;
    endcase
  end

  always_comb begin
    elCpC  = (state == S_CP_HI);
    elLpC  = (state == S_LATCH);
    elFlmC = (line == '0) && (state inside {S_ADDR, S_WAIT, S_CP_LO, S_CP_HI, S_LATCH});
  end

  // Running read address: +1 per byte and per line step, so no multiplier is needed.
  always_ff @(posedge clk) begin
    if (reset) begin
      line       <= '0;
      byteIdx    <= '0;
      rdAddrQ    <= '0;
      elDataQ    <= '0;
      subframeQ  <= 1'b0;
      frameDoneQ <= 1'b0;
    end else begin
      frameDoneQ <= 1'b0;
      unique case (state)
        S_IDLE: begin
          line    <= '0;
          byteIdx <= '0;
          rdAddrQ <= '0;
        end
        S_WAIT: begin
          if (cnt == RD_LAST) elDataQ <= subframeQ ? bus.rdData[7:4] : bus.rdData[3:0];
        end
        S_CP_HI: begin
          if (stateNext == S_ADDR) begin
            byteIdx <= byteIdx + 1'b1;
            rdAddrQ <= rdAddrQ + 15'd1;
          end
        end
        S_GAP: begin
          if (stateNext != S_GAP) begin
            byteIdx <= '0;
            if (lastLine) begin
              line       <= '0;
              rdAddrQ    <= '0;
              subframeQ  <= ~subframeQ;
              frameDoneQ <= 1'b1;
            end else begin
              line    <= line + 1'b1;
              rdAddrQ <= rdAddrQ + 15'd1;
            end
          end
        end
        default: ;
      endcase
      // panel data is blanked whenever the block is idle
      if (stateNext == S_IDLE) elDataQ <= '0;
    end
  end

  assign bus.rdAddr    = rdAddrQ;
  assign bus.elData    = elDataQ;
  assign bus.elCp      = elCpC;
  assign bus.elLp      = elLpC;
  assign bus.elFlm     = elFlmC;
  assign bus.subframe  = subframeQ;
  assign bus.frameDone = frameDoneQ;

endmodule

// File: tb/tb_el_panel_scanout.sv
// Directed bench: instance A (80x6, default timing) and instance B (4x2, RD_LAT=3, CP_DIV=1)
// with registered RAM models; expectations come from the line/byte timing formulas.
module tb_el_panel_scanout;

  localparam int A_BYTES  = 80;
  localparam int A_ACTIVE = A_BYTES * 6;          // 480
  localparam int A_LINE   = A_ACTIVE + 4 + 8;     // 492
  localparam int A_FRAME  = 6 * A_LINE;           // 2952
  localparam int B_ACTIVE = 4 * 6;                // 24
  localparam int B_LINE   = B_ACTIVE + 2 + 3;     // 29
  localparam int B_FRAME  = 2 * B_LINE;           // 58

  logic clk = 1'b0;
  logic resetA, resetB;
  logic ramConst;
  logic [7:0] pB0, pB1;
  int errors = 0;
  int checks = 0;
  int holdBadA = 0, holdBadB = 0;
  logic prevCpA = 1'b0, prevCpB = 1'b0;
  logic [3:0] prevDataA = '0, prevDataB = '0;

  el_panel_scanout_if busA ();
  el_panel_scanout_if busB ();

  el_panel_scanout #(.H_BYTES(80), .V_LINES(6)) u_dutA (
    .clk(clk), .reset(resetA), .bus(busA)
  );

  el_panel_scanout #(.H_BYTES(4), .V_LINES(2), .RD_LAT(3), .CP_DIV(1),
                     .LP_WIDTH(2), .LINE_GAP(3)) u_dutB (
    .clk(clk), .reset(resetB), .bus(busB)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    busA.rdData <= ramConst ? 8'hA5 : busA.rdAddr[7:0];
    pB0 <= {4'(busB.rdAddr[3:0] + 4'd9), 4'(busB.rdAddr[3:0] + 4'd1)};
    pB1 <= pB0;
    busB.rdData <= pB1;
  end

  // elData must not move while the panel shift clock is high
  always @(negedge clk) begin
    if (busA.elCp && prevCpA && busA.elData !== prevDataA) holdBadA <= holdBadA + 1;
    if (busB.elCp && prevCpB && busB.elData !== prevDataB) holdBadB <= holdBadB + 1;
    prevCpA <= busA.elCp;  prevDataA <= busA.elData;
    prevCpB <= busB.elCp;  prevDataB <= busB.elData;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit idleA();
    return busA.rdAddr === 15'd0 && busA.elData === 4'd0 && busA.elCp === 1'b0 &&
           busA.elLp === 1'b0 && busA.elFlm === 1'b0 && busA.frameDone === 1'b0;
  endfunction

  // Entered at the negedge of the frame's first ADDR cycle; returns at the frameDone cycle.
  task automatic runFrameA(input logic expSub, input bit useConst, input logic [3:0] constNib,
                           input int dropLine);
    int addrBad, dataBad, cpBad, lpBad, flmBad, subBad, fdBad;
    addrBad = 0; dataBad = 0; cpBad = 0; lpBad = 0; flmBad = 0; subBad = 0; fdBad = 0;
    for (int c = 0; c <= A_FRAME; c++) begin
      int ln, p, k;
      logic [3:0] expNib;
      if (c > 0) @(negedge clk);
      if (c == A_FRAME) begin
        check("frame_done", busA.frameDone, 1);
        check("frame_end_addr", busA.rdAddr, 0);
        check("frame_end_sub", busA.subframe, !expSub);
      end else begin
        ln = c / A_LINE;
        p  = c % A_LINE;
        k  = (p < A_ACTIVE) ? p / 6 : A_BYTES - 1;
        expNib = useConst ? constNib : 4'(k);
        if (busA.rdAddr !== 15'(ln * A_BYTES + k)) addrBad++;
        if (p < A_ACTIVE && p % 6 == 4 && busA.elData !== expNib) dataBad++;
        if (busA.elCp !== (p < A_ACTIVE && p % 6 >= 4)) cpBad++;
        if (busA.elLp !== (p >= A_ACTIVE && p < A_ACTIVE + 4)) lpBad++;
        if (busA.elFlm !== (ln == 0 && p < A_ACTIVE + 4)) flmBad++;
        if (busA.subframe !== expSub) subBad++;
        if (c > 0 && busA.frameDone !== 1'b0) fdBad++;
        if (c == dropLine * A_LINE + 100) busA.enable = 1'b0;
      end
    end
    check("addr_sequence", addrBad, 0);
    check("data_nibbles", dataBad, 0);
    check("cp_timing", cpBad, 0);
    check("lp_timing", lpBad, 0);
    check("flm_window", flmBad, 0);
    check("subframe_hold", subBad, 0);
    check("frame_done_early", fdBad, 0);
  endtask

  initial begin
    int bad;
    resetA = 1'b1; resetB = 1'b1;
    busA.enable = 1'b0; busB.enable = 1'b0;
    ramConst = 1'b0;
    repeat (2) @(negedge clk);
    resetA = 1'b0; resetB = 1'b0;

    // Idle with enable low
    @(negedge clk);
    check("reset_rdAddr", busA.rdAddr, 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!idleA() || busA.subframe !== 1'b0) bad++;
    end
    check("idle_outputs", bad, 0);

    // Frame 0: address-derived data, plane0
    busA.enable = 1'b1;
    @(negedge clk);
    runFrameA(1'b0, 1'b0, 4'h0, -1);

    // Frame 1: constant 0xA5, plane1, enable dropped on line 3
    ramConst = 1'b1;
    runFrameA(1'b1, 1'b1, 4'hA, 3);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!idleA() || busA.subframe !== 1'b0) bad++;
    end
    check("idle_after_drop", bad, 0);

    // Frame 2: constant 0xA5, plane0
    busA.enable = 1'b1;
    @(negedge clk);
    runFrameA(1'b0, 1'b1, 4'h5, -1);

    // Frame 3: reset in CP_HI of line 2, byte 5
    repeat (2 * A_LINE + 5 * 6 + 4) @(negedge clk);
    check("pre_reset_cp", busA.elCp, 1);
    check("pre_reset_sub", busA.subframe, 1);
    resetA = 1'b1;
    @(negedge clk);
    check("rst_rdAddr", busA.rdAddr, 0);
    check("rst_elData", busA.elData, 0);
    check("rst_panel", {busA.elCp, busA.elLp, busA.elFlm}, 0);
    check("rst_subframe", busA.subframe, 0);
    check("rst_frameDone", busA.frameDone, 0);
    resetA = 1'b0;
    @(negedge clk);
    check("restart_addr", busA.rdAddr, 0);
    check("restart_flm", busA.elFlm, 1);
    repeat (4) @(negedge clk);
    check("restart_data", busA.elData, 4'h5);
    repeat (2) @(negedge clk);
    check("restart_addr_next", busA.rdAddr, 1);

    // Instance B: RD_LAT=3, CP_DIV=1
    busB.enable = 1'b1;
    @(negedge clk);
    begin
      int addrBad, dataBad, cpBad, subBad;
      addrBad = 0; dataBad = 0; cpBad = 0; subBad = 0;
      for (int c = 0; c <= B_FRAME; c++) begin
        int ln, p, k;
        if (c > 0) @(negedge clk);
        if (c == B_FRAME) begin
          check("b_frame_done", busB.frameDone, 1);
          check("b_frame_end_sub", busB.subframe, 1);
        end else begin
          ln = c / B_LINE;
          p  = c % B_LINE;
          k  = (p < B_ACTIVE) ? p / 6 : 3;
          if (busB.rdAddr !== 15'(ln * 4 + k)) addrBad++;
          if (busB.elCp !== (p < B_ACTIVE && p % 6 == 5)) cpBad++;
          if (p < B_ACTIVE && p % 6 == 5 && busB.elData !== 4'(ln * 4 + k + 1)) dataBad++;
          if (busB.subframe !== 1'b0 || busB.frameDone !== 1'b0) subBad++;
        end
      end
      check("b_addr_sequence", addrBad, 0);
      check("b_cp_timing", cpBad, 0);
      check("b_data_latency", dataBad, 0);
      check("b_sub_fd_hold", subBad, 0);
    end

    @(negedge clk);
    check("a_data_hold_cp", holdBadA, 0);
    check("b_data_hold_cp", holdBadB, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
